core_sigout: RTL and testbench

Avalon-MM slave output PIO: the writer-side counterpart of the system's read-only input PIO. The CPU writes a data register that drives `out_port` directly, with atomic bit-set and bit-clear aliases. A hardware one-shot pulse engine inverts selected output bits for a programmed number of cycles and raises `irq` on completion. It sits on the CORE system interconnect; `out_port` goes to board pins or other fabric logic.

---
 rtl/core_sigout.sv | 129 ++++++++++++
 tb/tb_core_sigout.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/core_sigout.sv
// core_sigout: Avalon-MM output PIO with set/clear aliases and a one-shot
// pulse engine that inverts selected output bits for PULSE_LEN cycles.
module core_sigout #(
    parameter int               WIDTH             = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE       = '0,
    parameter logic [15:0]      DEFAULT_PULSE_LEN = 16'd100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    typedef enum logic {S_IDLE = 1'b0, S_PULSE = 1'b1} state_t;

    localparam logic [2:0] A_DATA   = 3'd0;
    localparam logic [2:0] A_PLEN   = 3'd1;
    localparam logic [2:0] A_PULSE  = 3'd2;
    localparam logic [2:0] A_STATUS = 3'd3;
    localparam logic [2:0] A_SET    = 3'd4;
    localparam logic [2:0] A_CLEAR  = 3'd5;

    state_t           r_state;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_mask;
    logic [15:0]      r_plen;
    logic [15:0]      r_count;
    logic             r_irq;
    logic             r_ovr;
    logic [31:0]      r_rdata;

    logic             w_wr;
    logic [WIDTH-1:0] w_wd;
    logic             w_busy;
    logic             w_pulse_wr;
    logic             w_pulse_end;
    logic             w_irq_clr;
    logic             w_ovr_clr;
    logic [15:0]      w_load_len;
    logic [31:0]      w_rdata;
    logic             w_unused;

    assign w_wr        = chipselect && !write_n;
    assign w_wd        = writedata[WIDTH-1:0];
    assign w_busy      = (r_state == S_PULSE);
    assign w_pulse_wr  = w_wr && (address == A_PULSE);
    assign w_pulse_end = w_busy && (r_count == 16'd1);
    assign w_irq_clr   = w_wr && (address == A_STATUS) && writedata[1];
    assign w_ovr_clr   = w_wr && (address == A_STATUS) && writedata[2];
    // A zero length still produces a one-cycle pulse.
    assign w_load_len  = (r_plen == 16'd0) ? 16'd1 : r_plen;
    // Upper write-data bits are architecturally ignored.
    assign w_unused    = ^writedata;

    assign out_port = r_data ^ r_mask;
    assign irq      = r_irq;
    assign readdata = r_rdata;

    // Read mux, zero-extended; write-only and unmapped addresses read 0.
    always_comb begin
        w_rdata = '0;
        case (address)
            A_DATA:   w_rdata[WIDTH-1:0] = r_data;
            A_PLEN:   w_rdata[15:0]      = r_plen;
            A_PULSE:  w_rdata[WIDTH-1:0] = r_mask;
            A_STATUS: w_rdata[2:0]       = {r_ovr, r_irq, w_busy};
            default:  w_rdata            = '0;
        endcase
    end

    // DATA (with set/clear aliases) and PULSE_LEN registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= RESET_VALUE;
            r_plen <= DEFAULT_PULSE_LEN;
        end else if (w_wr) begin
            case (address)
                A_DATA:  r_data <= w_wd;
                A_SET:   r_data <= r_data | w_wd;
                A_CLEAR: r_data <= r_data & ~w_wd;
                A_PLEN:  r_plen <= writedata[15:0];
                default: ;
            endcase
        end
    end

    // Pulse FSM plus irq/overrun flags; a set on the same edge beats a W1C.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_mask  <= '0;
            r_count <= '0;
            r_irq   <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pulse_wr && (w_wd != '0)) begin
                        r_mask  <= w_wd;
                        r_count <= w_load_len;
                        r_state <= S_PULSE;
                    end
                end
                S_PULSE: begin
                    r_count <= r_count - 16'd1;
                    if (w_pulse_end) begin
                        r_mask  <= '0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            r_irq <= w_pulse_end || (r_irq && !w_irq_clr);
            r_ovr <= (w_pulse_wr && w_busy) || (r_ovr && !w_ovr_clr);
        end
    end

    // Registered read data, sampled every clock regardless of chipselect.
    always_ff @(posedge clk) begin
        if (reset) r_rdata <= '0;
        else       r_rdata <= w_rdata;
    end

endmodule

// File: tb/tb_core_sigout.sv
// Self-checking bench for core_sigout: directed vector table, hand-written
// pulse corner sequences, and random traffic against a cycle-stamped model.
module tb_core_sigout;

    localparam int W = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [2:0]    address = '0;
    logic          chipselect = 1'b0;
    logic          write_n = 1'b1;
    logic [31:0]   writedata = '0;
    logic [31:0]   readdata;
    logic [W-1:0]  out_port;
    logic          irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    core_sigout #(.WIDTH(W), .RESET_VALUE(8'h00), .DEFAULT_PULSE_LEN(16'd100)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .out_port(out_port), .irq(irq)
    );

    // Reference model: a pulse is a start stamp plus length; it is active
    // until the edge numbered start+length.
    int           cyc = 0;
    logic [W-1:0] m_data, m_mask;
    logic [15:0]  m_plen;
    bit           m_busy, m_irq, m_ovr;
    int           m_end;
    logic [31:0]  m_rd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit wr, input logic [2:0] a, input logic [31:0] d);
        bit pre_busy, end_now, start;
        cyc++;
        if (r) begin
            m_data = 8'h00; m_mask = '0; m_plen = 16'd100;
            m_busy = 0; m_irq = 0; m_ovr = 0; m_rd = '0;
            return;
        end
        case (a)
            3'd0: m_rd = {24'h0, m_data};
            3'd1: m_rd = {16'h0, m_plen};
            3'd2: m_rd = {24'h0, m_mask};
            3'd3: m_rd = {29'h0, m_ovr, m_irq, m_busy};
            default: m_rd = '0;
        endcase
        pre_busy = m_busy;
        end_now  = pre_busy && (cyc == m_end);
        start    = !pre_busy && wr && (a == 3'd2) && (d[W-1:0] != '0);
        if (wr && a == 3'd0) m_data = d[W-1:0];
        if (wr && a == 3'd4) m_data = m_data | d[W-1:0];
        if (wr && a == 3'd5) m_data = m_data & ~d[W-1:0];
        if (end_now) begin m_busy = 0; m_mask = '0; end
        if (start) begin
            m_busy = 1; m_mask = d[W-1:0];
            m_end  = cyc + ((m_plen == 0) ? 1 : int'(m_plen));
        end
        m_irq = end_now || (m_irq && !(wr && a == 3'd3 && d[1]));
        m_ovr = (pre_busy && wr && a == 3'd2) || (m_ovr && !(wr && a == 3'd3 && d[2]));
        if (wr && a == 3'd1) m_plen = d[15:0];
    endtask

    // One clock: drive inputs, take the edge, update the model, compare.
    task automatic step(input bit r, input bit cs, input bit wn, input logic [2:0] a, input logic [31:0] d);
        reset = r; chipselect = cs; write_n = wn; address = a; writedata = d;
        @(posedge clk);
        model_edge(r, cs && !wn, a, d);
        #1;
        chk("model_out_port", {24'h0, out_port}, {24'h0, m_data ^ m_mask});
        chk("model_irq", {31'h0, irq}, {31'h0, m_irq});
        chk("model_readdata", readdata, m_rd);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d); step(0, 1, 0, a, d); endtask
    task automatic rd(input logic [2:0] a); step(0, 1, 1, a, '0); endtask
    task automatic idle(); step(0, 0, 1, 3'd0, '0); endtask

    typedef struct {
        bit          rst;
        bit          wr;
        logic [2:0]  a;
        logic [31:0] wd;
        logic [7:0]  eo;
        bit          ei;
        logic [31:0] er;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mkv(bit rst, bit w, logic [2:0] a, logic [31:0] wd,
                                 logic [7:0] eo, bit ei, logic [31:0] er);
        vec_t v;
        v.rst = rst; v.wr = w; v.a = a; v.wd = wd; v.eo = eo; v.ei = ei; v.er = er;
        return v;
    endfunction

    initial begin
        // reset values and read-back
        tbl.push_back(mkv(1, 0, 3'd0, 32'h0,        8'h00, 0, 32'd0));
        tbl.push_back(mkv(0, 0, 3'd0, 32'h0,        8'h00, 0, 32'd0));
        tbl.push_back(mkv(0, 0, 3'd1, 32'h0,        8'h00, 0, 32'd100));
        tbl.push_back(mkv(0, 0, 3'd3, 32'h0,        8'h00, 0, 32'd0));
        // DATA, SET, CLEAR
        tbl.push_back(mkv(0, 1, 3'd0, 32'hA5,       8'hA5, 0, 32'd0));
        tbl.push_back(mkv(0, 1, 3'd4, 32'h0F,       8'hAF, 0, 32'd0));
        tbl.push_back(mkv(0, 1, 3'd5, 32'h81,       8'h2E, 0, 32'd0));
        tbl.push_back(mkv(0, 0, 3'd0, 32'h0,        8'h2E, 0, 32'h2E));
        // 5-cycle pulse of mask 0x03
        tbl.push_back(mkv(0, 1, 3'd1, 32'd5,        8'h2E, 0, 32'd100));
        tbl.push_back(mkv(0, 1, 3'd0, 32'h0,        8'h00, 0, 32'h2E));
        tbl.push_back(mkv(0, 1, 3'd2, 32'h03,       8'h03, 0, 32'd0));
        tbl.push_back(mkv(0, 0, 3'd3, 32'h0,        8'h03, 0, 32'd1));
        tbl.push_back(mkv(0, 0, 3'd2, 32'h0,        8'h03, 0, 32'h03));
        tbl.push_back(mkv(0, 0, 3'd3, 32'h0,        8'h03, 0, 32'd1));
        tbl.push_back(mkv(0, 0, 3'd3, 32'h0,        8'h03, 0, 32'd1));
        tbl.push_back(mkv(0, 0, 3'd3, 32'h0,        8'h00, 1, 32'd1));
        tbl.push_back(mkv(0, 0, 3'd3, 32'h0,        8'h00, 1, 32'd2));
        tbl.push_back(mkv(0, 1, 3'd3, 32'h2,        8'h00, 0, 32'd2));
        // PULSE_LEN=0 gives a single-cycle pulse
        tbl.push_back(mkv(0, 1, 3'd1, 32'd0,        8'h00, 0, 32'd5));
        tbl.push_back(mkv(0, 1, 3'd2, 32'h80,       8'h80, 0, 32'd0));
        tbl.push_back(mkv(0, 0, 3'd3, 32'h0,        8'h00, 1, 32'd1));
        tbl.push_back(mkv(0, 1, 3'd3, 32'h2,        8'h00, 0, 32'd2));
        // unmapped addresses and ignored upper write bits
        tbl.push_back(mkv(0, 1, 3'd6, 32'hFF,       8'h00, 0, 32'd0));
        tbl.push_back(mkv(0, 0, 3'd7, 32'h0,        8'h00, 0, 32'd0));
        tbl.push_back(mkv(0, 1, 3'd0, 32'hFFFFFF3C, 8'h3C, 0, 32'd0));
        tbl.push_back(mkv(0, 0, 3'd0, 32'h0,        8'h3C, 0, 32'h3C));
        tbl.push_back(mkv(0, 1, 3'd4, 32'hFFFFFFC0, 8'hFC, 0, 32'd0));
        tbl.push_back(mkv(0, 1, 3'd5, 32'hFFFFFFFF, 8'h00, 0, 32'd0));

        foreach (tbl[i]) begin
            step(tbl[i].rst, 1'b1, !tbl[i].wr, tbl[i].a, tbl[i].wd);
            chk($sformatf("vec%0d_out_port", i), {24'h0, out_port}, {24'h0, tbl[i].eo});
            chk($sformatf("vec%0d_irq", i), {31'h0, irq}, {31'h0, tbl[i].ei});
            chk($sformatf("vec%0d_readdata", i), readdata, tbl[i].er);
        end

        // overrun and DATA write inside a 10-cycle pulse
        wr(3'd1, 32'd10);
        wr(3'd2, 32'h01);               chk("ovr_start_out", {24'h0, out_port}, 32'h01);
        wr(3'd2, 32'h02);               chk("ovr_ignored_out", {24'h0, out_port}, 32'h01);
        wr(3'd0, 32'h01);               chk("ovr_data_inv_out", {24'h0, out_port}, 32'h00);
        rd(3'd3);                       chk("ovr_status", readdata, 32'h5);
        repeat (6) idle();              chk("ovr_late_out", {24'h0, out_port}, 32'h00);
        chk("ovr_late_irq", {31'h0, irq}, 32'h0);
        idle();                         chk("ovr_end_out", {24'h0, out_port}, 32'h01);
        chk("ovr_end_irq", {31'h0, irq}, 32'h1);

        // pulse end on the same edge as an irq W1C: set wins
        wr(3'd3, 32'h6);                chk("clr_irq", {31'h0, irq}, 32'h0);
        wr(3'd0, 32'h0);
        wr(3'd1, 32'd3);
        wr(3'd2, 32'h01);
        idle();
        idle();
        wr(3'd3, 32'h2);                chk("coincide_irq", {31'h0, irq}, 32'h1);
        chk("coincide_out", {24'h0, out_port}, 32'h00);
        wr(3'd3, 32'h6);                chk("w1c_irq", {31'h0, irq}, 32'h0);
        rd(3'd3);                       chk("w1c_status", readdata, 32'h0);

        // reset in the middle of a pulse aborts it without irq
        wr(3'd1, 32'd10);
        wr(3'd0, 32'h5A);
        wr(3'd2, 32'hFF);               chk("rstp_out", {24'h0, out_port}, 32'hA5);
        idle();
        idle();
        step(1, 0, 1, 3'd0, '0);        chk("rstp_reset_out", {24'h0, out_port}, 32'h00);
        chk("rstp_reset_irq", {31'h0, irq}, 32'h0);
        repeat (12) idle();             chk("rstp_after_out", {24'h0, out_port}, 32'h00);
        chk("rstp_after_irq", {31'h0, irq}, 32'h0);
        rd(3'd1);                       chk("rstp_plen", readdata, 32'd100);

        // random traffic checked against the model
        for (int n = 0; n < 600; n++) begin
            bit          r, cs, wn;
            logic [2:0]  a;
            logic [31:0] d;
            r  = ($urandom_range(0, 149) == 0);
            cs = ($urandom_range(0, 3) != 0);
            wn = $urandom_range(0, 1) != 0;
            a  = 3'($urandom_range(0, 7));
            d  = $urandom;
            if (a == 3'd1) d[15:0] = 16'($urandom_range(0, 8));
            step(r, cs, wn, a, d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
